// File: rtl/pwm_nch_deadband_pkg.sv
// Shared defaults and types for the multi-channel dead-band PWM.
package pwm_pkg;

  localparam int PWM_WIDTH    = 11;
  localparam int PWM_NCH      = 2;
  localparam int PWM_DB_WIDTH = 6;

  typedef logic [PWM_WIDTH-1:0] duty_t;

endpackage

// File: rtl/pwm_nch_deadband_dt_chan.sv
// One complementary output pair: duty compare against the shared counter,
// then dead-band shaping so that only the falling edges of hi/lo are immediate.
module pwm_dt_chan
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int DB_WIDTH = PWM_DB_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic [WIDTH-1:0]    cnt_i,
  input  logic [WIDTH-1:0]    duty_i,
  input  logic [DB_WIDTH-1:0] dead_time_i,
  output logic                pwm_hi_o,
  output logic                pwm_lo_o
);

  localparam int RUN_W = DB_WIDTH + 1;
  localparam logic [RUN_W-1:0] RUN_SAT = {1'b1, {DB_WIDTH{1'b0}}};

  logic             raw;
  logic             settled;
  logic             raw_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             hi_q, lo_q;

  // run_d = length of the current constant stretch of raw, including this
  // cycle; an output may rise only once that stretch exceeds the dead time.
  always_comb begin
    raw = (cnt_i < duty_i);
    if (raw != raw_q) begin
      run_d = RUN_W'(1);
    end else if (run_q == RUN_SAT) begin
      run_d = run_q;
    end else begin
      run_d = run_q + 1'b1;
    end
    settled = (run_d > {1'b0, dead_time_i});
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !en_i) begin
      raw_q <= 1'b0;
      run_q <= '0;
      hi_q  <= 1'b0;
      lo_q  <= 1'b0;
    end else begin
      raw_q <= raw;
      run_q <= run_d;
      hi_q  <= raw & settled;
      lo_q  <= ~raw & settled;
    end
  end

  assign pwm_hi_o = hi_q;
  assign pwm_lo_o = lo_q;

endmodule

// File: rtl/pwm_nch_deadband.sv
// Multi-channel complementary PWM: shared period counter, shadowed duty and
// dead-time registers swapped in on the last count of each period.
module pwm_nch_deadband
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int NCH      = PWM_NCH,
  parameter int DB_WIDTH = PWM_DB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic [NCH-1:0]       duty_wr,
  input  logic [DB_WIDTH-1:0]  dead_time,
  output logic                 period_start,
  output logic [NCH-1:0]       pwm_hi,
  output logic [NCH-1:0]       pwm_lo
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 period_start_q;
  logic [NCH*WIDTH-1:0] pending_q, pending_d;
  logic [NCH*WIDTH-1:0] active_q, active_d;
  logic [DB_WIDTH-1:0]  active_dt_q, active_dt_d;
  logic                 wrap;

  // A duty write landing on the wrap cycle goes straight into the load.
  always_comb begin
    wrap      = (cnt_q == CNT_MAX);
    cnt_d     = en ? cnt_q + 1'b1 : '0;
    pending_d = pending_q;
    for (int i = 0; i < NCH; i++) begin
      if (duty_wr[i]) begin
        pending_d[i*WIDTH +: WIDTH] = duty[i*WIDTH +: WIDTH];
      end
    end
    active_d    = wrap ? pending_d : active_q;
    active_dt_d = wrap ? dead_time : active_dt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      pending_q      <= '0;
      active_q       <= '0;
      active_dt_q    <= '0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= en & wrap;
      pending_q      <= pending_d;
      active_q       <= active_d;
      active_dt_q    <= active_dt_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pwm_dt_chan #(
      .WIDTH    (WIDTH),
      .DB_WIDTH (DB_WIDTH)
    ) u_chan (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .cnt_i       (cnt_q),
      .duty_i      (active_q[g*WIDTH +: WIDTH]),
      .dead_time_i (active_dt_q),
      .pwm_hi_o    (pwm_hi[g]),
      .pwm_lo_o    (pwm_lo[g])
    );
  end

endmodule

// File: tb/tb_pwm_nch_deadband.sv
// Scoreboard bench for pwm_nch_deadband: cycle reference model feeds an
// expectation queue, a monitor compares, and per-period counts are checked.
module tb_pwm_nch_deadband;
  import pwm_pkg::*;

  localparam int WIDTH  = PWM_WIDTH;
  localparam int NCH    = PWM_NCH;
  localparam int DBW    = PWM_DB_WIDTH;
  localparam int PERIOD = 1 << WIDTH;
  localparam int MAXC   = PERIOD - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [NCH*WIDTH-1:0] duty;
  logic [NCH-1:0]       duty_wr;
  logic [DBW-1:0]       dead_time;
  logic                 period_start;
  logic [NCH-1:0]       pwm_hi;
  logic [NCH-1:0]       pwm_lo;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [NCH-1:0] hi;
    logic [NCH-1:0] lo;
    logic           ps;
  } exp_t;

  exp_t expQ[$];

  // reference model state
  int        mCnt;
  int        mDt;
  int        mAct[NCH];
  int        mPend[NCH];
  bit [63:0] mHist[NCH];
  int        mLen[NCH];

  // per-window measurements
  int winHi[NCH];
  int winLo[NCH];
  int winGap[NCH];
  int winCompl[NCH];
  int winPs;

  always #5 clk = ~clk;

  pwm_nch_deadband dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .duty         (duty),
    .duty_wr      (duty_wr),
    .dead_time    (dead_time),
    .period_start (period_start),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo)
  );

  // Reference model: at each rising edge, works out what the outputs must be
  // after that edge from the rules (raw = count below duty; an output may only
  // be high once raw has held its level for dead_time+1 cycles in a row).
  initial forever begin
    exp_t e;
    bit   raw;
    bit   ok;
    @(posedge clk);
    e = '0;
    if (!rst_n) begin
      mCnt = 0;
      mDt  = 0;
      for (int c = 0; c < NCH; c++) begin
        mAct[c]  = 0;
        mPend[c] = 0;
        mHist[c] = '0;
        mLen[c]  = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        raw = (mCnt < mAct[c]);
        if (en) begin
          mHist[c] = {mHist[c][62:0], raw};
          if (mLen[c] < 64) mLen[c]++;
          ok = (mLen[c] >= mDt + 1);
          for (int k = 0; k <= mDt; k++) begin
            if (mHist[c][k] != raw) ok = 1'b0;
          end
          e.hi[c] = raw && ok;
          e.lo[c] = !raw && ok;
        end else begin
          mHist[c] = '0;
          mLen[c]  = 0;
        end
      end
      e.ps = en && (mCnt == MAXC);
      for (int c = 0; c < NCH; c++) begin
        if (duty_wr[c]) mPend[c] = int'(duty[c*WIDTH +: WIDTH]);
      end
      if (mCnt == MAXC) begin
        mAct = mPend;
        mDt  = int'(dead_time);
      end
      mCnt = en ? (mCnt + 1) % PERIOD : 0;
    end
    expQ.push_back(e);
  end

  // Monitor: every falling edge pops one expectation and compares, and
  // separately guards against both switches of a pair being on together.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      compared++;
      if (pwm_hi !== e.hi || pwm_lo !== e.lo || period_start !== e.ps) begin
        mismatched++;
        $display("[TB] FAIL scoreboard t=%0t: got hi=%b lo=%b ps=%b, expected hi=%b lo=%b ps=%b",
                 $time, pwm_hi, pwm_lo, period_start, e.hi, e.lo, e.ps);
      end
    end
    compared++;
    if ((pwm_hi & pwm_lo) !== '0) begin
      mismatched++;
      $display("[TB] FAIL both_high t=%0t: got hi=%b lo=%b, expected no overlap",
               $time, pwm_hi, pwm_lo);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Writes the masked channels' duty words and sets the dead time.
  task automatic applyStimulus(input logic [NCH-1:0] mask, input int d0, input int d1,
                               input int dt);
    int dv[NCH];
    dv[0] = d0;
    dv[1] = d1;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) duty[c*WIDTH +: WIDTH] = WIDTH'(dv[c]);
    dead_time = DBW'(dt);
    duty_wr   = mask;
    @(negedge clk);
    duty_wr = '0;
  endtask

  task automatic waitPeriodStart(output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 2 * PERIOD + 16; i++) begin
      @(negedge clk);
      if (!found && period_start === 1'b1) begin
        found  = 1'b1;
        cycles = i;
        break;
      end
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL period_start_timeout: got none, expected one within %0d cycles",
               2 * PERIOD + 16);
    end
  endtask

  // Counts output levels over one period starting at the current falling
  // edge; optionally writes ch0 duty when the window reaches index wrAt.
  task automatic measureWindow(input int wrAt, input int wrVal);
    for (int c = 0; c < NCH; c++) begin
      winHi[c]    = 0;
      winLo[c]    = 0;
      winGap[c]   = 0;
      winCompl[c] = 0;
    end
    winPs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      if (i == wrAt) begin
        duty[WIDTH-1:0] = wrVal[WIDTH-1:0];
        duty_wr         = NCH'(1);
      end else begin
        duty_wr = '0;
      end
      for (int c = 0; c < NCH; c++) begin
        winHi[c]    += int'(pwm_hi[c]);
        winLo[c]    += int'(pwm_lo[c]);
        winGap[c]   += int'(!pwm_hi[c] && !pwm_lo[c]);
        winCompl[c] += int'(pwm_hi[c] ^ pwm_lo[c]);
      end
      winPs += int'(period_start);
    end
    duty_wr = '0;
  endtask

  initial begin
    int cyc;
    int offHold;
    rst_n     = 1'b0;
    en        = 1'b0;
    duty      = '0;
    duty_wr   = '0;
    dead_time = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_hi", int'(pwm_hi), 0);
    checkOutput("reset_lo", int'(pwm_lo), 0);
    checkOutput("reset_ps", int'(period_start), 0);
    rst_n = 1'b1;
    en    = 1'b1;

    $display("[TB] 25%% duty, no dead time");
    applyStimulus(2'b11, 'h200, 'h000, 0);
    waitPeriodStart(cyc);
    waitPeriodStart(cyc);
    checkOutput("t1_period_len", cyc, PERIOD);
    measureWindow(-1, 0);
    checkOutput("t1_hi0", winHi[0], 512);
    checkOutput("t1_lo0", winLo[0], 1536);
    checkOutput("t1_compl0", winCompl[0], PERIOD);
    checkOutput("t1_ps_count", winPs, 1);

    $display("[TB] duty extremes");
    applyStimulus(2'b11, 0, 'h7FF, 0);
    waitPeriodStart(cyc);
    waitPeriodStart(cyc);
    measureWindow(-1, 0);
    checkOutput("t2_hi0", winHi[0], 0);
    checkOutput("t2_lo0", winLo[0], PERIOD);
    checkOutput("t2_hi1", winHi[1], 2047);
    checkOutput("t2_lo1", winLo[1], 1);

    $display("[TB] 50%% duty, dead time 8");
    applyStimulus(2'b11, 'h400, 'h400, 8);
    waitPeriodStart(cyc);
    waitPeriodStart(cyc);
    measureWindow(-1, 0);
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("t3_hi%0d", c), winHi[c], 1016);
      checkOutput($sformatf("t3_lo%0d", c), winLo[c], 1016);
      checkOutput($sformatf("t3_gap%0d", c), winGap[c], 16);
    end

    $display("[TB] shadowed duty update mid-period");
    applyStimulus(2'b11, 'h200, 'h200, 0);
    waitPeriodStart(cyc);
    waitPeriodStart(cyc);
    measureWindow('h100, 'h600);
    checkOutput("t4_cur_hi0", winHi[0], 512);
    checkOutput("t4_cur_hi1", winHi[1], 512);
    waitPeriodStart(cyc);
    measureWindow(-1, 0);
    checkOutput("t4_next_hi0", winHi[0], 1536);
    checkOutput("t4_next_hi1", winHi[1], 512);

    $display("[TB] pulse shorter than dead time");
    applyStimulus(2'b01, 10, 0, 16);
    waitPeriodStart(cyc);
    waitPeriodStart(cyc);
    measureWindow(-1, 0);
    checkOutput("t5_hi0", winHi[0], 0);
    checkOutput("t5_lo0", winLo[0], PERIOD - 26);

    $display("[TB] reset mid-period and enable drop");
    waitPeriodStart(cyc);
    repeat ('h300) @(negedge clk);
    checkOutput("t6_pre_lo", int'(pwm_lo), 3);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_hi", int'(pwm_hi), 0);
    checkOutput("t6_rst_lo", int'(pwm_lo), 0);
    checkOutput("t6_rst_ps", int'(period_start), 0);
    rst_n = 1'b1;
    waitPeriodStart(cyc);
    checkOutput("t6_restart_len", cyc, PERIOD);
    applyStimulus(2'b11, 'h400, 'h400, 0);
    waitPeriodStart(cyc);
    repeat ('h100) @(negedge clk);
    checkOutput("t6_pre_en_hi", int'(pwm_hi), 3);
    en = 1'b0;
    @(negedge clk);
    checkOutput("t6_en_hi", int'(pwm_hi), 0);
    checkOutput("t6_en_lo", int'(pwm_lo), 0);
    en = 1'b1;

    $display("[TB] randomized traffic");
    offHold = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      duty_wr = '0;
      rst_n   = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        for (int c = 0; c < NCH; c++) begin
          case ($urandom_range(0, 3))
            0:       duty[c*WIDTH +: WIDTH] = '0;
            1:       duty[c*WIDTH +: WIDTH] = WIDTH'(MAXC);
            2:       duty[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 40));
            default: duty[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, MAXC));
          endcase
        end
        duty_wr = NCH'($urandom_range(1, (1 << NCH) - 1));
      end
      if ($urandom_range(0, 299) == 0) dead_time = DBW'($urandom_range(0, (1 << DBW) - 1));
      if (offHold > 0) begin
        offHold--;
        en = (offHold == 0);
      end else if ($urandom_range(0, 2999) == 0) begin
        en      = 1'b0;
        offHold = $urandom_range(1, 20);
      end
      if ($urandom_range(0, 5999) == 0) rst_n = 1'b0;
    end
    rst_n   = 1'b1;
    en      = 1'b1;
    duty_wr = '0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
